dmem_arbiter: RTL

- Shares the single-port data memory between two requesters.
  - Port 0: the CPU MEM stage.
  - Port 1: the bench/debug loader that preloads and inspects data memory.
- One transaction in flight at a time. Memory access latency is fixed at LAT cycles.
- Drives `p0_stall` so the pipeline freezes while the CPU access is pending or losing arbitration.
- Sits between the CPU load/store path and the `d_memory` array.

---
 rtl/dmem_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares the single-port data memory between the CPU MEM stage
//            (port 0) and the debug loader (port 1), one access in flight.
//            Define DMEM_ARB_FIXED_PRIO_EN to give the CPU fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    output logic              p0_stall,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              misalign_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] LAT_LOAD = 4'(LAT - 1);

    logic [1:0]        r_state;
    logic              r_gnt_id;
    logic              r_gnt_we;
    logic [3:0]        r_lat_cnt;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_wdata_hold;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;
    logic              r_p0_rvalid;
    logic              r_p1_rvalid;
    logic              r_misalign;

    logic              w_gnt_next;
    logic              w_issue;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [ADDR_W-1:0] w_iss_addr;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // CPU wins every tie; port 1 is served only while port 0 is idle.
    always_comb begin
        w_gnt_next = p0_req ? 1'b0 : 1'b1;
    end
`else
    logic r_last_gnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_gnt <= 1'b1;
        end else if (w_issue) begin
            r_last_gnt <= r_gnt_id;
        end
    end

    always_comb begin
        w_gnt_next = p0_req ? 1'b0 : 1'b1;
        if (p0_req && p1_req) begin
            w_gnt_next = ~r_last_gnt;
        end
    end
`endif

    assign w_issue     = (r_state == S_ISSUE);
    assign w_sel_we    = r_gnt_id ? p1_we    : p0_we;
    assign w_sel_addr  = r_gnt_id ? p1_addr  : p0_addr;
    assign w_sel_wdata = r_gnt_id ? p1_wdata : p0_wdata;
    assign w_iss_addr  = {w_sel_addr[ADDR_W-1:2], 2'b00};

    // Address/data are live only in ISSUE; otherwise the last issued values are held.
    assign mem_en    = w_issue;
    assign mem_we    = w_issue & w_sel_we;
    assign mem_addr  = w_issue ? w_iss_addr  : r_addr_hold;
    assign mem_wdata = w_issue ? w_sel_wdata : r_wdata_hold;

    assign p0_rdata     = r_p0_rdata;
    assign p1_rdata     = r_p1_rdata;
    assign p0_rvalid    = r_p0_rvalid;
    assign p1_rvalid    = r_p1_rvalid;
    assign p0_stall     = p0_req & ~r_p0_rvalid;
    assign misalign_err = r_misalign;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_gnt_id     <= 1'b0;
            r_gnt_we     <= 1'b0;
            r_lat_cnt    <= 4'd0;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
            r_p0_rvalid  <= 1'b0;
            r_p1_rvalid  <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (p0_req || p1_req) begin
                        r_gnt_id <= w_gnt_next;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_gnt_we     <= w_sel_we;
                    r_lat_cnt    <= LAT_LOAD;
                    r_addr_hold  <= w_iss_addr;
                    r_wdata_hold <= w_sel_wdata;
                    if (w_sel_addr[1:0] != 2'b00) begin
                        r_misalign <= 1'b1;
                    end
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // mem_rdata is valid in the last WAIT cycle; register it so
                    // rdata and rvalid appear together during RESP.
                    if (r_lat_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        if (r_gnt_id) begin
                            r_p1_rvalid <= 1'b1;
                            if (!r_gnt_we) begin
                                r_p1_rdata <= mem_rdata;
                            end
                        end else begin
                            r_p0_rvalid <= 1'b1;
                            if (!r_gnt_we) begin
                                r_p0_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
